// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial_adder block.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The subtract controls exist only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic             ready_out;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             out_valid_out;
  logic             out_ready_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_in;
  logic             overflow_out;

  modport master (
    output start_in, a_in, b_in, c_in, out_ready_in, sub_in,
    input  ready_out, sum_out, carry_out, out_valid_out, overflow_out
  );
  modport slave (
    input  start_in, a_in, b_in, c_in, out_ready_in, sub_in,
    output ready_out, sum_out, carry_out, out_valid_out, overflow_out
  );
`else
  modport master (
    output start_in, a_in, b_in, c_in, out_ready_in,
    input  ready_out, sum_out, carry_out, out_valid_out
  );
  modport slave (
    input  start_in, a_in, b_in, c_in, out_ready_in,
    output ready_out, sum_out, carry_out, out_valid_out
  );
`endif
endinterface

// File: rtl/serial_adder_fa_digit.sv
// fa_digit: combinational DIGIT-bit ripple of full-adder cells.
// c_msb_o taps the carry into the top cell, used for two's-complement overflow.
module fa_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o  = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add (or subtract with SERIAL_ADDER_SUB_EN) processed DIGIT bits per clock.
// Result registers hold the last answer across retirement until the next DONE or reset.
//   state | meaning
//   IDLE  | ready for an operation, operands captured on start
//   RUN   | one DIGIT slice per edge, N = WIDTH/DIGIT edges
//   DONE  | result valid, held until out_ready_in
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk_in,
  input logic          rst_n_in,
  serial_adder_if.slave bus
);
  import serial_adder_pkg::*;

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(WIDTH, DIGIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must be positive and divide WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sub_sel;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;
  logic [DIGIT-1:0] slice_s;
  logic             slice_cout;

`ifdef SERIAL_ADDER_SUB_EN
  logic slice_cmsb;
  logic ovf_q, ovf_d;

  assign sub_sel = bus.sub_in;
`else
  logic cmsb_unused;

  assign sub_sel = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so only the capture path differs.
  assign b_cap = bus.b_in ^ {WIDTH{sub_sel}};
  assign c_cap = sub_sel | bus.c_in;

  fa_digit #(.DIGIT(DIGIT)) u_slice (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .cin_i   (carry_q),
    .s_o     (slice_s),
    .cout_o  (slice_cout),
`ifdef SERIAL_ADDER_SUB_EN
    .c_msb_o (slice_cmsb)
`else
    .c_msb_o (cmsb_unused)
`endif
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          a_d     = bus.a_in;
          b_d     = b_cap;
          carry_d = c_cap;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = WIDTH'({slice_s, sum_q} >> DIGIT);
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          res_d   = sum_d;
          cout_d  = slice_cout;
`ifdef SERIAL_ADDER_SUB_EN
          ovf_d   = slice_cmsb ^ slice_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow_out = ovf_q;
`endif

  assign bus.ready_out     = (state_q == IDLE);
  assign bus.out_valid_out = (state_q == DONE);
  assign bus.sum_out       = res_q;
  assign bus.carry_out     = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT=1 and DIGIT=4 instances checked against an arithmetic model.
// Works with or without SERIAL_ADDER_SUB_EN defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus1 ();
  serial_adder_if #(.WIDTH(8)) bus4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus4));

  typedef struct packed {
    logic       ready;
    logic       valid;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } obs_t;

  // {overflow, carry, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic sub);
    int ua, ub, sa, sb, u, s;
    logic [7:0] sm;
    logic cy, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u  = ua - ub;
      s  = sa - sb;
      cy = (ua >= ub);
    end else begin
      u  = ua + ub + int'(c);
      s  = sa + sb + int'(c);
      cy = (u > 255);
    end
    sm = 8'(u & 255);
    ov = (s > 127) || (s < -128);
    return {ov, cy, sm};
  endfunction

  function automatic obs_t observe(input int sel);
    obs_t o;
    o.ovf = 1'b0;
    if (sel == 1) begin
      o.ready = bus1.ready_out;
      o.valid = bus1.out_valid_out;
      o.sum   = bus1.sum_out;
      o.carry = bus1.carry_out;
`ifdef SERIAL_ADDER_SUB_EN
      o.ovf   = bus1.overflow_out;
`endif
    end else begin
      o.ready = bus4.ready_out;
      o.valid = bus4.out_valid_out;
      o.sum   = bus4.sum_out;
      o.carry = bus4.carry_out;
`ifdef SERIAL_ADDER_SUB_EN
      o.ovf   = bus4.overflow_out;
`endif
    end
    return o;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic rdy);
    if (sel == 1) begin
      bus1.start_in = st; bus1.a_in = a; bus1.b_in = b; bus1.c_in = c; bus1.out_ready_in = rdy;
    end else begin
      bus4.start_in = st; bus4.a_in = a; bus4.b_in = b; bus4.c_in = c; bus4.out_ready_in = rdy;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic set_sub(input int sel, input logic sub);
    if (sel == 1) bus1.sub_in = sub;
    else          bus4.sub_in = sub;
  endtask
`endif

  // Issue one op at #1 after an edge, check latency, result, hold for 'hold' cycles, retire.
  task automatic run_check(input string name, input int sel, input logic [7:0] a,
                           input logic [7:0] b, input logic c, input logic sub, input int hold);
    obs_t o;
    logic [9:0] exp;
    int n, edges;
    n   = (sel == 1) ? 8 : 2;
    exp = model(a, b, c, sub);
    o   = observe(sel);
    tests_run++;
    if (o.ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s ready_before got %b want 1", name, o.ready);
    end
    drive(sel, 1'b1, a, b, c, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    set_sub(sel, sub);
`endif
    @(posedge clk); #1;
    edges = 0;
    o = observe(sel);
    while (!o.valid && edges < 40) begin
      tests_run++;
      if (o.ready !== 1'b0) begin
        tests_failed++; $display("FAIL %s ready_run got %b want 0", name, o.ready);
      end
      // start and operands wiggle during RUN and must be ignored
      drive(sel, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
      set_sub(sel, 1'($urandom_range(0, 1)));
`endif
      @(posedge clk); #1;
      edges++;
      o = observe(sel);
    end
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (edges != n) begin
      tests_failed++; $display("FAIL %s latency got %0d want %0d", name, edges, n);
    end
    tests_run++;
    if (o.sum !== exp[7:0]) begin
      tests_failed++; $display("FAIL %s sum got %h want %h", name, o.sum, exp[7:0]);
    end
    tests_run++;
    if (o.carry !== exp[8]) begin
      tests_failed++; $display("FAIL %s carry got %b want %b", name, o.carry, exp[8]);
    end
`ifdef SERIAL_ADDER_SUB_EN
    tests_run++;
    if (o.ovf !== exp[9]) begin
      tests_failed++; $display("FAIL %s overflow got %b want %b", name, o.ovf, exp[9]);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      o = observe(sel);
      tests_run++;
      if (o.valid !== 1'b1 || o.ready !== 1'b0 || {o.ovf & exp[9], o.carry, o.sum} !== {o.ovf & exp[9], exp[8:0]}) begin
        tests_failed++;
        $display("FAIL %s hold%0d got v=%b r=%b c=%b s=%h want v=1 r=0 c=%b s=%h",
                 name, i, o.valid, o.ready, o.carry, o.sum, exp[8], exp[7:0]);
      end
`ifdef SERIAL_ADDER_SUB_EN
      tests_run++;
      if (o.ovf !== exp[9]) begin
        tests_failed++; $display("FAIL %s hold_ovf got %b want %b", name, o.ovf, exp[9]);
      end
`endif
    end
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    o = observe(sel);
    tests_run++;
    if (o.valid !== 1'b0 || o.ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s retire got v=%b r=%b want v=0 r=1", name, o.valid, o.ready);
    end
    tests_run++;
    if ({o.carry, o.sum} !== exp[8:0]) begin
      tests_failed++; $display("FAIL %s kept_result got %h want %h", name, {o.carry, o.sum}, exp[8:0]);
    end
  endtask

  task automatic test_reset;
    obs_t o;
    for (int s = 1; s <= 4; s += 3) begin
      o = observe(s);
      tests_run++;
      if (o.ready !== 1'b1 || o.valid !== 1'b0 || o.sum !== 8'h00 || o.carry !== 1'b0 || o.ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d got r=%b v=%b s=%h c=%b o=%b want r=1 v=0 s=00 c=0 o=0",
                 s, o.ready, o.valid, o.sum, o.carry, o.ovf);
      end
    end
  endtask

  task automatic test_directed;
    run_check("add_5a_3c", 1, 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    run_check("add_ff_01", 1, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_check("add_ff_ff_c", 1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1);
  endtask

  task automatic test_backpressure;
    run_check("backpressure", 1, 8'hC3, 8'h21, 1'b1, 1'b0, 5);
  endtask

  task automatic test_digit4;
    run_check("digit4_9c_78", 4, 8'h9C, 8'h78, 1'b0, 1'b0, 2);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    run_check("sub_10_20", 1, 8'h10, 8'h20, 1'b1, 1'b1, 1);
    run_check("sub_80_01", 1, 8'h80, 8'h01, 1'b0, 1'b1, 1);
    run_check("sub4_80_01", 4, 8'h80, 8'h01, 1'b0, 1'b1, 0);
  endtask
`endif

  task automatic test_mid_run_reset;
    obs_t o1, o4;
    drive(1, 1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o1 = observe(1);
    o4 = observe(4);
    tests_run++;
    if (o1.ready !== 1'b1 || o1.valid !== 1'b0 || o1.sum !== 8'h00 || o1.carry !== 1'b0 || o1.ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset dut1 got r=%b v=%b s=%h c=%b o=%b want r=1 v=0 s=00 c=0 o=0",
               o1.ready, o1.valid, o1.sum, o1.carry, o1.ovf);
    end
    tests_run++;
    if (o4.sum !== 8'h00 || o4.carry !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset dut4 got s=%h c=%b want s=00 c=0", o4.sum, o4.carry);
    end
    #3;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      o1 = observe(1);
      tests_run++;
      if (o1.valid !== 1'b0 || o1.ready !== 1'b1) begin
        tests_failed++; $display("FAIL discarded_op got v=%b r=%b want v=0 r=1", o1.valid, o1.ready);
      end
    end
    run_check("after_reset", 1, 8'h01, 8'h02, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back(input int sel);
    obs_t o;
    logic [7:0] a, b;
    logic c;
    logic [9:0] exp;
    logic [9:0] sb[$];
    int cyc, last, got, n;
    n = (sel == 1) ? 8 : 2;
    cyc = 0; last = -1; got = 0;
`ifdef SERIAL_ADDER_SUB_EN
    set_sub(sel, 1'b0);
`endif
    o = observe(sel);
    while (got < 4 && cyc < 200) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      drive(sel, 1'b1, a, b, c, 1'b1);
      if (o.ready) sb.push_back(model(a, b, c, 1'b0));
      @(posedge clk); #1;
      cyc++;
      o = observe(sel);
      if (o.valid) begin
        got++;
        exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
        tests_run++;
        if ({o.carry, o.sum} !== exp[8:0]) begin
          tests_failed++; $display("FAIL b2b_result dut%0d got %h want %h", sel, {o.carry, o.sum}, exp[8:0]);
        end
`ifdef SERIAL_ADDER_SUB_EN
        tests_run++;
        if (o.ovf !== exp[9]) begin
          tests_failed++; $display("FAIL b2b_overflow dut%0d got %b want %b", sel, o.ovf, exp[9]);
        end
`endif
        if (last >= 0) begin
          tests_run++;
          if (cyc - last != n + 2) begin
            tests_failed++; $display("FAIL b2b_interval dut%0d got %0d want %0d", sel, cyc - last, n + 2);
          end
        end
        last = cyc;
      end
    end
    tests_run++;
    if (got < 4) begin
      tests_failed++; $display("FAIL b2b_timeout dut%0d got %0d results want 4", sel, got);
    end
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (2 * n + 4) @(posedge clk);
    #1;
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    o = observe(sel);
    tests_run++;
    if (o.ready !== 1'b1 || o.valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_drain dut%0d got r=%b v=%b want r=1 v=0", sel, o.ready, o.valid);
    end
  endtask

  task automatic test_random;
    logic sub;
    for (int i = 0; i < 24; i++) begin
      sub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      run_check("random", (i % 2 == 0) ? 1 : 4, 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), sub, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    set_sub(1, 1'b0);
    set_sub(4, 1'b0);
`endif
    #1;
    test_reset;
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed;
    test_backpressure;
    test_digit4;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    test_mid_run_reset;
    test_back_to_back(1);
    test_back_to_back(4);
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
